cache_assoc_wb: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement.
- Sits between the datapath and a backing RAM, and replaces the fixed 2-way / 4-set cache.
- A CPU-side req/ready/done handshake and a memory-side req/ack handshake replace the old single-edge combinational RAM access.
- Write hits never trigger write-back, and the valid bit is part of the hit test.

---
 rtl/cache_assoc_wb.sv | 243 ++++++++++++++++++++++++
 tb/tb_cache_assoc_wb.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back / write-allocate cache with true-LRU replacement.
// The CPU side uses a req/ready/done handshake and the memory side uses a req/ack handshake.
module cache_assoc_wb #(
  parameter int DATA_W = 8,
  parameter int TAG_W = 8,
  parameter int INDEX_W = 2,
  parameter int WAYS = 2,
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req,
  input  logic                     mode,
  input  logic [INDEX_W-1:0]       index,
  input  logic [TAG_W-1:0]         tag,
  input  logic [DATA_W-1:0]        data,
  output logic                     ready,
  output logic                     done,
  output logic [DATA_W-1:0]        data_out,
  output logic                     hit_out,
  output logic                     wBack_out,
  output logic                     load_out,
  output logic [AGE_W-1:0]         way_out,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [TAG_W+INDEX_W-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata
);
  localparam int SETS = 1 << INDEX_W;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_FILL      = 3'd3;
  localparam logic [2:0] S_RESPOND   = 3'd4;

  logic [2:0]         state;
  logic               r_mode;
  logic [INDEX_W-1:0] r_index;
  logic [TAG_W-1:0]   r_tag;
  logic [DATA_W-1:0]  r_data;
  logic [AGE_W-1:0]   r_way;
  logic               r_wback;

  logic               valid    [SETS][WAYS];
  logic               dirty    [SETS][WAYS];
  logic [AGE_W-1:0]   age      [SETS][WAYS];
  logic [TAG_W-1:0]   tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0]  data_mem [SETS][WAYS];

  logic [WAYS-1:0]    match;
  logic               hit;
  logic [AGE_W-1:0]   hit_way;
  logic [AGE_W-1:0]   vic_way;
  logic               vic_dirty;
  logic               acc_en;
  logic [AGE_W-1:0]   acc_way;
  logic               line_we;
  logic [DATA_W-1:0]  line_wdata;
  logic               line_dirty;

  assign ready = (state == S_IDLE);
  assign done  = (state == S_RESPOND);

  // Victim: lowest invalid way wins, otherwise the oldest way of the set.
  always_comb begin
    match   = '0;
    hit_way = '0;
    vic_way = '0;
    for (int w = 0; w < WAYS; w++)
      match[w] = valid[r_index][w] && (tag_mem[r_index][w] == r_tag);
    for (int w = WAYS - 1; w >= 0; w--)
      if (match[w]) hit_way = AGE_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (age[r_index][w] == AGE_W'(WAYS - 1)) vic_way = AGE_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[r_index][w]) vic_way = AGE_W'(w);
    hit       = $onehot(match);
    vic_dirty = valid[r_index][vic_way] && dirty[r_index][vic_way];
  end

  always_comb begin
    acc_en     = 1'b0;
    acc_way    = r_way;
    line_we    = 1'b0;
    line_wdata = r_data;
    line_dirty = 1'b1;
    case (state)
      S_LOOKUP: begin
        if (hit) begin
          acc_en  = 1'b1;
          acc_way = hit_way;
          line_we = r_mode;
        end else if (!vic_dirty && r_mode) begin
          acc_en  = 1'b1;
          acc_way = vic_way;
          line_we = 1'b1;
        end
      end
      S_WRITEBACK: begin
        if (mem_ack && r_mode) begin
          acc_en  = 1'b1;
          line_we = 1'b1;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          acc_en     = 1'b1;
          line_we    = 1'b1;
          line_wdata = mem_rdata;
          line_dirty = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (line_we) begin
      tag_mem[r_index][acc_way]  <= r_tag;
      data_mem[r_index][acc_way] <= line_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      r_mode    <= 1'b0;
      r_index   <= '0;
      r_tag     <= '0;
      r_data    <= '0;
      r_way     <= '0;
      r_wback   <= 1'b0;
      data_out  <= '0;
      hit_out   <= 1'b0;
      wBack_out <= 1'b0;
      load_out  <= 1'b0;
      way_out   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
          age[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      // Ages stay a permutation: only ways younger than the accessed one get older.
      if (acc_en) begin
        for (int k = 0; k < WAYS; k++) begin
          if (AGE_W'(k) == acc_way)
            age[r_index][k] <= '0;
          else if (age[r_index][k] < age[r_index][acc_way])
            age[r_index][k] <= age[r_index][k] + 1'b1;
        end
      end
      if (line_we) begin
        valid[r_index][acc_way] <= 1'b1;
        dirty[r_index][acc_way] <= line_dirty;
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            r_mode  <= mode;
            r_index <= index;
            r_tag   <= tag;
            r_data  <= data;
            r_wback <= 1'b0;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            r_way     <= hit_way;
            data_out  <= r_mode ? r_data : data_mem[r_index][hit_way];
            hit_out   <= 1'b1;
            wBack_out <= 1'b0;
            load_out  <= 1'b0;
            way_out   <= hit_way;
            state     <= S_RESPOND;
          end else begin
            r_way <= vic_way;
            if (vic_dirty) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_mem[r_index][vic_way], r_index};
              mem_wdata <= data_mem[r_index][vic_way];
              r_wback   <= 1'b1;
              state     <= S_WRITEBACK;
            end else if (!r_mode) begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {r_tag, r_index};
              state    <= S_FILL;
            end else begin
              data_out  <= r_data;
              hit_out   <= 1'b0;
              wBack_out <= 1'b0;
              load_out  <= 1'b0;
              way_out   <= vic_way;
              state     <= S_RESPOND;
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            if (r_mode) begin
              mem_req   <= 1'b0;
              data_out  <= r_data;
              hit_out   <= 1'b0;
              wBack_out <= 1'b1;
              load_out  <= 1'b0;
              way_out   <= r_way;
              state     <= S_RESPOND;
            end else begin
              mem_addr <= {r_tag, r_index};
              state    <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            data_out  <= mem_rdata;
            hit_out   <= 1'b0;
            wBack_out <= r_wback;
            load_out  <= 1'b1;
            way_out   <= r_way;
            state     <= S_RESPOND;
          end
        end
        S_RESPOND: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_assoc_wb.sv
// Scoreboard bench for cache_assoc_wb: a reference cache model predicts responses and
// memory traffic, a responder plays the backing RAM, and both sides are checked.
module tb_cache_assoc_wb;
  logic       clock;
  logic       reset_n;
  logic       req;
  logic       mode;
  logic [1:0] index;
  logic [7:0] tag;
  logic [7:0] data;
  logic       ready;
  logic       done;
  logic [7:0] data_out;
  logic       hit_out;
  logic       wBack_out;
  logic       load_out;
  logic [0:0] way_out;
  logic       mem_req;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  typedef struct {
    logic [7:0] data;
    logic       hit;
    logic       wb;
    logic       load;
    logic [0:0] way;
  } resp_t;

  typedef struct {
    logic       we;
    logic [9:0] addr;
    logic [7:0] wdata;
  } mem_op_t;

  resp_t       resp_q[$];
  mem_op_t     mem_q[$];
  logic [10:0] mem_log[$];

  int check_count = 0;
  int fail_count = 0;
  int mem_delay = 3;
  int mem_count = 0;

  logic [7:0] ram     [1024];
  logic [7:0] ref_ram [1024];
  logic       m_valid [4][2];
  logic       m_dirty [4][2];
  logic [7:0] m_tag   [4][2];
  logic [7:0] m_data  [4][2];
  int         m_age   [4][2];

  logic [7:0] last_data;
  logic       last_hit;
  logic       last_wb;
  logic       last_load;
  logic [0:0] last_way;

  cache_assoc_wb #(.DATA_W(8), .TAG_W(8), .INDEX_W(2), .WAYS(2)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .mode(mode), .index(index),
    .tag(tag), .data(data), .ready(ready), .done(done), .data_out(data_out),
    .hit_out(hit_out), .wBack_out(wBack_out), .load_out(load_out), .way_out(way_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_age[s][w] = w;
      end
  endtask

  task automatic model_touch(input int s, input int w);
    int old_age;
    old_age = m_age[s][w];
    for (int k = 0; k < 2; k++)
      if (k != w && m_age[s][k] < old_age) m_age[s][k]++;
    m_age[s][w] = 0;
  endtask

  // Predicts the response and any memory phases for one access, then updates the model.
  task automatic model_access(input logic m, input logic [1:0] idx, input logic [7:0] tg,
                              input logic [7:0] dt, output logic exp_hit);
    resp_t   r;
    mem_op_t op;
    int      s;
    int      hw;
    int      vw;
    s = int'(idx);
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == tg) hw = w;
    r.wb = 1'b0;
    r.load = 1'b0;
    if (hw >= 0) begin
      r.hit = 1'b1;
      r.way = 1'(hw);
      if (m) begin
        m_data[s][hw] = dt;
        m_dirty[s][hw] = 1'b1;
      end
      r.data = m_data[s][hw];
      model_touch(s, hw);
    end else begin
      r.hit = 1'b0;
      vw = -1;
      for (int w = 0; w < 2; w++)
        if (!m_valid[s][w] && vw < 0) vw = w;
      if (vw < 0)
        for (int w = 0; w < 2; w++)
          if (m_age[s][w] == 1) vw = w;
      r.way = 1'(vw);
      if (m_valid[s][vw] && m_dirty[s][vw]) begin
        r.wb = 1'b1;
        op.we = 1'b1;
        op.addr = {m_tag[s][vw], idx};
        op.wdata = m_data[s][vw];
        mem_q.push_back(op);
        ref_ram[op.addr] = op.wdata;
      end
      if (m) begin
        m_data[s][vw] = dt;
        m_dirty[s][vw] = 1'b1;
      end else begin
        op.we = 1'b0;
        op.addr = {tg, idx};
        op.wdata = 8'h00;
        mem_q.push_back(op);
        m_data[s][vw] = ref_ram[op.addr];
        m_dirty[s][vw] = 1'b0;
        r.load = 1'b1;
      end
      m_valid[s][vw] = 1'b1;
      m_tag[s][vw] = tg;
      r.data = m_data[s][vw];
      model_touch(s, vw);
    end
    exp_hit = r.hit;
    resp_q.push_back(r);
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] idx, input logic [7:0] tg, input logic [7:0] dt);
    logic  exp_hit;
    resp_t r;
    int    cycles;
    bit    seen;
    model_access(m, idx, tg, dt, exp_hit);
    for (int i = 0; i < 20 && !ready; i++) @(negedge clock);
    if (!ready) begin
      checkOutput("ready_timeout", {31'd0, ready}, 32'd1);
      void'(resp_q.pop_back());
      return;
    end
    req = 1'b1;
    mode = m;
    index = idx;
    tag = tg;
    data = dt;
    @(posedge clock);
    #1 req = 1'b0;
    cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      cycles++;
      if (cycles == 1) checkOutput("ready_busy", {31'd0, ready}, 32'd0);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checkOutput("done_timeout", {31'd0, seen}, 32'd1);
      void'(resp_q.pop_front());
      return;
    end
    r = resp_q.pop_front();
    last_data = data_out;
    last_hit = hit_out;
    last_wb = wBack_out;
    last_load = load_out;
    last_way = way_out;
    checkOutput("data_out", {24'd0, data_out}, {24'd0, r.data});
    checkOutput("hit_out", {31'd0, hit_out}, {31'd0, r.hit});
    checkOutput("wBack_out", {31'd0, wBack_out}, {31'd0, r.wb});
    checkOutput("load_out", {31'd0, load_out}, {31'd0, r.load});
    checkOutput("way_out", {31'd0, way_out}, {31'd0, r.way});
    if (exp_hit) checkOutput("hit_latency", cycles, 32'd2);
  endtask

  // Backing RAM: acks each phase after mem_delay cycles and checks it against the model.
  initial begin
    mem_op_t op;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        mem_ack = 1'b0;
        mem_count = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        mem_count = 0;
      end else if (mem_req) begin
        mem_count++;
        if (mem_count >= mem_delay) begin
          mem_log.push_back({mem_we, mem_addr});
          checkOutput("mem_pending", {31'd0, mem_q.size() > 0}, 32'd1);
          if (mem_q.size() > 0) begin
            op = mem_q.pop_front();
            checkOutput("mem_we", {31'd0, mem_we}, {31'd0, op.we});
            checkOutput("mem_addr", {22'd0, mem_addr}, {22'd0, op.addr});
            if (op.we) checkOutput("mem_wdata", {24'd0, mem_wdata}, {24'd0, op.wdata});
          end
          if (mem_we) ram[mem_addr] = mem_wdata;
          else mem_rdata = ram[mem_addr];
          mem_ack = 1'b1;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'(i) ^ 8'hA5;
      ref_ram[i] = 8'(i) ^ 8'hA5;
    end
    ram[10'h011] = 8'h55;
    ref_ram[10'h011] = 8'h55;
    model_reset();
    req = 1'b0;
    mode = 1'b0;
    index = 2'd0;
    tag = 8'h00;
    data = 8'h00;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rst_ready", {31'd0, ready}, 32'd1);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_data_out", {24'd0, data_out}, 32'd0);
    checkOutput("rst_hit_out", {31'd0, hit_out}, 32'd0);
    checkOutput("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] cold read, hit, write hit");
    mem_log.delete();
    applyStimulus(1'b0, 2'd1, 8'h04, 8'h00);
    checkOutput("cold_data", {24'd0, last_data}, 32'h55);
    checkOutput("cold_way", {31'd0, last_way}, 32'd0);
    checkOutput("cold_fill_addr", (mem_log.size() == 1) ? {21'd0, mem_log[0]} : 32'hFFFF, 32'h011);
    applyStimulus(1'b0, 2'd1, 8'h04, 8'h00);
    applyStimulus(1'b1, 2'd1, 8'h04, 8'hAA);
    applyStimulus(1'b0, 2'd1, 8'h04, 8'h00);
    checkOutput("write_hit_readback", {24'd0, last_data}, 32'hAA);

    $display("[TB] LRU eviction with write-back");
    applyStimulus(1'b0, 2'd1, 8'h07, 8'h00);
    applyStimulus(1'b0, 2'd1, 8'h07, 8'h00);
    mem_log.delete();
    applyStimulus(1'b0, 2'd1, 8'h09, 8'h00);
    checkOutput("evict_phases", mem_log.size(), 32'd2);
    if (mem_log.size() == 2) begin
      checkOutput("evict_wb_addr", {21'd0, mem_log[0]}, 32'h411);
      checkOutput("evict_fill_addr", {21'd0, mem_log[1]}, 32'h025);
    end
    checkOutput("evict_wb_flag", {31'd0, last_wb}, 32'd1);

    $display("[TB] write miss to clean and dirty victims");
    mem_log.delete();
    applyStimulus(1'b1, 2'd1, 8'h0B, 8'h3C);
    checkOutput("write_miss_no_mem", mem_log.size(), 32'd0);
    applyStimulus(1'b0, 2'd1, 8'h0B, 8'h00);
    applyStimulus(1'b1, 2'd1, 8'h0D, 8'h77);
    applyStimulus(1'b0, 2'd1, 8'h0E, 8'h00);
    applyStimulus(1'b1, 2'd2, 8'h10, 8'h01);
    applyStimulus(1'b1, 2'd2, 8'h11, 8'h02);
    applyStimulus(1'b1, 2'd2, 8'h12, 8'h03);
    applyStimulus(1'b0, 2'd2, 8'h10, 8'h00);

    $display("[TB] random traffic");
    for (int n = 0; n < 30; n++) begin
      mem_delay = $urandom_range(1, 4);
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 3) + 32), 8'($urandom_range(0, 255)));
    end

    $display("[TB] reset during fill");
    mem_delay = 3;
    applyStimulus(1'b0, 2'd1, 8'h09, 8'h00);
    applyStimulus(1'b0, 2'd1, 8'h09, 8'h00);
    checkOutput("pre_reset_hit", {31'd0, last_hit}, 32'd1);
    mem_delay = 10;
    for (int i = 0; i < 20 && !ready; i++) @(negedge clock);
    req = 1'b1;
    mode = 1'b0;
    index = 2'd2;
    tag = 8'h33;
    @(posedge clock);
    #1 req = 1'b0;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clock);
    checkOutput("fill_req_seen", {31'd0, mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1 checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    mem_q.delete();
    resp_q.delete();
    @(negedge clock);
    checkOutput("post_reset_ready", {31'd0, ready}, 32'd1);
    mem_delay = 2;
    applyStimulus(1'b0, 2'd1, 8'h09, 8'h00);
    checkOutput("post_reset_miss", {31'd0, last_hit}, 32'd0);
    checkOutput("post_reset_queue", mem_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
